// File: rtl/wbs_host_master.sv
// wbs_host_master
// Wishbone classic-cycle initiator fed by a simple command/response port.
// A narrow command issues one 32-bit beat; a wide command issues two beats
// (lower word at the 8-byte aligned address, upper word at +4) separated by
// a one-cycle strobe gap so the slave's ack can drop between beats.
// Each beat is guarded by an ack timeout so a dead slave produces an error
// response instead of a hang.
//
// Ports:
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (accept when both high at posedge)
//   cmd_we, cmd_wide       write enable, 64-bit (two-beat) select
//   cmd_adr, cmd_wdata     byte address, write data (narrow uses [31:0])
//   rsp_valid              one-cycle completion pulse
//   rsp_err                1 = beat timed out
//   rsp_rdata              read data (missing words are zero)
//   wbm_*                  Wishbone classic master signals
module wbs_host_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic        cmd_wide,
  input  logic [31:0] cmd_adr,
  input  logic [63:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [63:0] rsp_rdata,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  // Last counter value before the abort fires: the counter starts at zero in
  // the first strobe cycle, so reaching TIMEOUT_CYCLES-1 without ack means
  // the strobe has been high for exactly TIMEOUT_CYCLES cycles.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LO, GAP, HI, RESP} state_t;

  state_t state_reg, state_next;

  // Latched command
  logic            wide_reg, wide_next;
  logic [31:0]     adr_reg, adr_next;
  logic [31:0]     wdata_hi_reg, wdata_hi_next;
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;

  // Registered outputs
  logic        cmd_ready_reg, cmd_ready_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic        rsp_err_reg, rsp_err_next;
  logic [63:0] rsp_rdata_reg, rsp_rdata_next;
  logic        cyc_reg, cyc_next;
  logic        stb_reg, stb_next;
  logic        we_reg, we_next;
  logic [3:0]  sel_reg, sel_next;
  logic [31:0] wbm_adr_reg, wbm_adr_next;
  logic [31:0] wbm_dat_reg, wbm_dat_next;

  logic        finish;
  logic        timeout;
  logic [31:0] lo_adr;

  // Narrow beats align to 4 bytes, wide transfers to 8 bytes.
  assign lo_adr = cmd_adr & (cmd_wide ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC);

  always_comb begin
    state_next     = state_reg;
    wide_next      = wide_reg;
    adr_next       = adr_reg;
    wdata_hi_next  = wdata_hi_reg;
    to_cnt_next    = to_cnt_reg;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    cyc_next       = cyc_reg;
    stb_next       = stb_reg;
    we_next        = we_reg;
    sel_next       = sel_reg;
    wbm_adr_next   = wbm_adr_reg;
    wbm_dat_next   = wbm_dat_reg;
    finish         = 1'b0;
    timeout        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready_reg) begin
          state_next     = LO;
          wide_next      = cmd_wide;
          adr_next       = lo_adr;
          wdata_hi_next  = cmd_wdata[63:32];
          to_cnt_next    = '0;
          rsp_rdata_next = '0;
          cyc_next       = 1'b1;
          stb_next       = 1'b1;
          we_next        = cmd_we;
          sel_next       = 4'hF;
          wbm_adr_next   = lo_adr;
          wbm_dat_next   = cmd_wdata[31:0];
        end
      end

      LO, HI: begin
        if (wbm_ack_i) begin
          // Ack beats the timeout even if both land in the same cycle.
          if (!we_reg) begin
            if (state_reg == LO) rsp_rdata_next[31:0]  = wbm_dat_i;
            else                 rsp_rdata_next[63:32] = wbm_dat_i;
          end
          if (state_reg == LO && wide_reg) begin
            state_next = GAP;
            stb_next   = 1'b0;
          end else begin
            finish = 1'b1;
          end
        end else if (to_cnt_reg == TO_LAST) begin
          finish  = 1'b1;
          timeout = 1'b1;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end

      GAP: begin
        // Ack is not sampled here; strobe is low for one cycle.
        state_next   = HI;
        stb_next     = 1'b1;
        to_cnt_next  = '0;
        wbm_adr_next = adr_reg + 32'd4;
        wbm_dat_next = wdata_hi_reg;
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (finish) begin
      state_next     = RESP;
      cyc_next       = 1'b0;
      stb_next       = 1'b0;
      we_next        = 1'b0;
      sel_next       = 4'h0;
      rsp_valid_next = 1'b1;
      rsp_err_next   = timeout;
    end

    cmd_ready_next = (state_next == IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg     <= IDLE;
      wide_reg      <= 1'b0;
      adr_reg       <= '0;
      wdata_hi_reg  <= '0;
      to_cnt_reg    <= '0;
      cmd_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      cyc_reg       <= 1'b0;
      stb_reg       <= 1'b0;
      we_reg        <= 1'b0;
      sel_reg       <= 4'h0;
      wbm_adr_reg   <= '0;
      wbm_dat_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      wide_reg      <= wide_next;
      adr_reg       <= adr_next;
      wdata_hi_reg  <= wdata_hi_next;
      to_cnt_reg    <= to_cnt_next;
      cmd_ready_reg <= cmd_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
      cyc_reg       <= cyc_next;
      stb_reg       <= stb_next;
      we_reg        <= we_next;
      sel_reg       <= sel_next;
      wbm_adr_reg   <= wbm_adr_next;
      wbm_dat_reg   <= wbm_dat_next;
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign wbm_cyc_o = cyc_reg;
  assign wbm_stb_o = stb_reg;
  assign wbm_we_o  = we_reg;
  assign wbm_sel_o = sel_reg;
  assign wbm_adr_o = wbm_adr_reg;
  assign wbm_dat_o = wbm_dat_reg;

endmodule

// File: tb/tb_wbs_host_master.sv
// Testbench for wbs_host_master: a behavioural Wishbone slave with per-beat
// ack delays, a beat scoreboard checked at each beat start, and a response
// scoreboard checked by a separate monitor whenever rsp_valid is high.
module tb_wbs_host_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_wide;
  logic [31:0] cmd_adr;
  logic [63:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  always #5 clk = ~clk;

  wbs_host_master #(.TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst_i),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_wide (cmd_wide),
    .cmd_adr  (cmd_adr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_rdata(rsp_rdata),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i)
  );

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          at;
  } rsp_t;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } beat_t;

  rsp_t        rsp_q[$];
  beat_t       beat_q[$];
  int          delay_q[$];
  logic [31:0] rd_q[$];

  int passed = 0;
  int total  = 0;
  int cycle  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    else passed++;
  endtask

  // Queue one expected beat. d = ack delay (ack in stb cycle d+2), -1 = never.
  // For reads, dat is the word the slave returns.
  task automatic beat(input logic [31:0] adr, input logic we, input logic [31:0] dat, input int d);
    beat_t b;
    b.adr = adr;
    b.we  = we;
    b.dat = dat;
    beat_q.push_back(b);
    delay_q.push_back(d);
    if (!we && d >= 0) rd_q.push_back(dat);
  endtask

  // Issue one command; lat = cycles from accept edge to the cycle rsp_valid
  // is visible. keep leaves cmd_valid high for a following command.
  task automatic send(input logic we, input logic wide, input logic [31:0] adr,
                      input logic [63:0] wdata, input logic err, input logic [63:0] rdata,
                      input int lat, input bit keep, input bit want_rsp, output int acc);
    logic r;
    rsp_t e;
    cmd_we    = we;
    cmd_wide  = wide;
    cmd_adr   = adr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 200; k++) begin
      r = cmd_ready;
      @(posedge clk); #1;
      if (r) begin
        acc = cycle;
        break;
      end
    end
    if (acc < 0) begin
      total++;
      $display("FAIL accept_timeout: got no accept within 200 cycles, expected accept");
    end else if (want_rsp) begin
      e.err   = err;
      e.rdata = rdata;
      e.at    = acc + lat;
      rsp_q.push_back(e);
    end
    if (!keep) begin
      // Scramble the command port; the DUT must use its latched copy.
      cmd_valid = 1'b0;
      cmd_adr   = $urandom;
      cmd_wdata = {$urandom, $urandom};
      cmd_we    = ~we;
      cmd_wide  = ~wide;
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      if (rsp_q.size() == 0 && cmd_ready) break;
      @(posedge clk); #1;
    end
    chk("drain_rsp_q", rsp_q.size(), 0);
  endtask

  // Slave: ack is driven just after an edge so the DUT samples it at the next.
  initial begin : slave
    int    n;
    int    d;
    beat_t b;
    n = 0;
    d = 0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (wbm_cyc_o && wbm_stb_o) begin
        n++;
        if (n == 1) begin
          if (delay_q.size() > 0) d = delay_q.pop_front();
          else d = 0;
          if (beat_q.size() == 0) begin
            total++;
            $display("FAIL beat_unexpected: got beat at adr 0x%h, expected none", wbm_adr_o);
          end else begin
            b = beat_q.pop_front();
            chk("beat_adr", wbm_adr_o, b.adr);
            chk("beat_we", wbm_we_o, b.we);
            chk("beat_sel", wbm_sel_o, 4'hF);
            if (b.we) chk("beat_dat", wbm_dat_o, b.dat);
          end
        end
        if (d >= 0 && n == d + 2) begin
          wbm_ack_i = 1'b1;
          if (!wbm_we_o && rd_q.size() > 0) wbm_dat_i = rd_q.pop_front();
          else wbm_dat_i = 32'h0;
        end else begin
          wbm_ack_i = 1'b0;
        end
      end else begin
        n = 0;
        wbm_ack_i = 1'b0;
      end
    end
  end

  initial begin : monitor
    rsp_t e;
    forever begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          total++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 at cycle %0d, expected none", cycle);
        end else begin
          e = rsp_q.pop_front();
          $display("rsp at cycle %0d: err=%0b rdata=0x%h", cycle, rsp_err, rsp_rdata);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_cycle", cycle, e.at);
          chk("rsp_cyc_low", wbm_cyc_o, 1'b0);
          chk("rsp_stb_low", wbm_stb_o, 1'b0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int a, a1, a2, a3;
    wb_rst_i  = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_wide  = 1'b0;
    cmd_adr   = 32'h0;
    cmd_wdata = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_cyc", wbm_cyc_o, 1'b0);
    chk("rst_stb", wbm_stb_o, 1'b0);
    chk("rst_we", wbm_we_o, 1'b0);
    chk("rst_sel", wbm_sel_o, 4'h0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 64'h0);
    wb_rst_i = 1'b0;

    // Narrow write
    beat(32'h3000_0000, 1'b1, 32'h0000_0001, 0);
    send(1'b1, 1'b0, 32'h3000_0000, 64'h1, 1'b0, 64'h0, 2, 1'b0, 1'b1, a);
    wait_idle();

    // Wide read
    beat(32'h3001_0008, 1'b0, 32'hDEAD_BEEF, 0);
    beat(32'h3001_000C, 1'b0, 32'h0000_1010, 0);
    send(1'b0, 1'b1, 32'h3001_0008, 64'h0, 1'b0, 64'h0000_1010_DEAD_BEEF, 5, 1'b0, 1'b1, a);
    wait_idle();

    // Wide write from an address with bit 2 set; upper beat acked late
    beat(32'h3002_0018, 1'b1, 32'h7654_3210, 0);
    beat(32'h3002_001C, 1'b1, 32'hFEDC_BA98, 1);
    send(1'b1, 1'b1, 32'h3002_001C, 64'hFEDC_BA98_7654_3210, 1'b0, 64'h0, 6, 1'b0, 1'b1, a);
    wait_idle();

    // Narrow read timeout, unaligned address
    beat(32'h3000_0010, 1'b0, 32'h0, -1);
    send(1'b0, 1'b0, 32'h3000_0012, 64'h0, 1'b1, 64'h0, TO, 1'b0, 1'b1, a);
    wait_idle();

    // Wide read: lower word acked, upper word times out
    beat(32'h3001_0020, 1'b0, 32'h1234_5678, 0);
    beat(32'h3001_0024, 1'b0, 32'h0, -1);
    send(1'b0, 1'b1, 32'h3001_0024, 64'h0, 1'b1, 64'h0000_0000_1234_5678, 3 + TO, 1'b0, 1'b1, a);
    wait_idle();

    // Reset during the upper beat of a wide write: no response expected
    beat(32'h3000_0040, 1'b1, 32'hAAAA_0000, 0);
    beat(32'h3000_0044, 1'b1, 32'h5555_FFFF, -1);
    send(1'b1, 1'b1, 32'h3000_0040, 64'h5555_FFFF_AAAA_0000, 1'b0, 64'h0, 0, 1'b0, 1'b0, a);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("hi_stb", wbm_stb_o, 1'b1);
    chk("hi_adr", wbm_adr_o, 32'h3000_0044);
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    wb_rst_i = 1'b0;
    chk("midrst_cyc", wbm_cyc_o, 1'b0);
    chk("midrst_stb", wbm_stb_o, 1'b0);
    chk("midrst_cmd_ready", cmd_ready, 1'b1);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);

    // Narrow read after the reset
    beat(32'h3000_0008, 1'b0, 32'hCAFE_0001, 0);
    send(1'b0, 1'b0, 32'h3000_0008, 64'h0, 1'b0, 64'h0000_0000_CAFE_0001, 2, 1'b0, 1'b1, a);
    wait_idle();

    // Back-to-back narrow reads, ack delays 0/3/1
    beat(32'h3000_0100, 1'b0, 32'h1111_1111, 0);
    beat(32'h3000_0104, 1'b0, 32'h2222_2222, 3);
    beat(32'h3000_0108, 1'b0, 32'h3333_3333, 1);
    send(1'b0, 1'b0, 32'h3000_0100, 64'h0, 1'b0, 64'h1111_1111, 2, 1'b1, 1'b1, a1);
    send(1'b0, 1'b0, 32'h3000_0104, 64'h0, 1'b0, 64'h2222_2222, 5, 1'b1, 1'b1, a2);
    chk("b2b_gap1", a2 - a1, 4);
    send(1'b0, 1'b0, 32'h3000_010B, 64'h0, 1'b0, 64'h3333_3333, 3, 1'b0, 1'b1, a3);
    chk("b2b_gap2", a3 - a2, 7);
    wait_idle();

    chk("beats_left", beat_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
